// File: rtl/fridge_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : fridge_status_tx
// Purpose  : Snapshots fridge settings and sends them as one UART-style frame.
//            Optional macro FRIDGE_TX_PARITY_EN adds an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module fridge_status_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i,
    input  logic       req,
    input  logic [4:0] fgt,
    input  logic [4:0] frt,
    input  logic [4:0] fgc,
    input  logic [4:0] frc,
    input  logic       ice,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef FRIDGE_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    localparam logic [7:0] c_baud_last = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0] c_bit_last  = 5'd20;

    state_t      r_state, w_state;
    logic [7:0]  r_baud,  w_baud;
    logic [4:0]  r_bit,   w_bit;
    logic [20:0] r_shift, w_shift;
    logic        r_tx,    w_tx;
    logic        r_busy,  w_busy;
    logic        r_done,  w_done;
    logic        w_baud_end;
`ifdef FRIDGE_TX_PARITY_EN
    logic        r_par,   w_par;
`endif

    assign w_baud_end = (r_baud == c_baud_last);

    // tx/busy/done are computed one step ahead so the outputs come straight from flops
    always_comb begin
        w_state = r_state;
        w_baud  = r_baud;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_busy  = r_busy;
        w_done  = 1'b0;
`ifdef FRIDGE_TX_PARITY_EN
        w_par   = r_par;
`endif
        if (!i) begin
            w_state = S_IDLE;
            w_baud  = 8'd0;
            w_bit   = 5'd0;
            w_tx    = 1'b1;
            w_busy  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_tx   = 1'b1;
                    w_busy = 1'b0;
                    if (req) begin
                        w_state = S_START;
                        w_shift = {ice, frc, fgc, frt, fgt};
`ifdef FRIDGE_TX_PARITY_EN
                        w_par   = ^{ice, frc, fgc, frt, fgt};
`endif
                        w_baud  = 8'd0;
                        w_bit   = 5'd0;
                        w_tx    = 1'b0;
                        w_busy  = 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        w_baud  = 8'd0;
                        w_state = S_DATA;
                        w_tx    = r_shift[0];
                    end else begin
                        w_baud = r_baud + 8'd1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        w_baud = 8'd0;
                        if (r_bit == c_bit_last) begin
                            w_bit = 5'd0;
`ifdef FRIDGE_TX_PARITY_EN
                            w_state = S_PARITY;
                            w_tx    = r_par;
`else
                            w_state = S_STOP;
                            w_tx    = 1'b1;
`endif
                        end else begin
                            // snapshot shifts out LSB first; next bit sits at [1]
                            w_bit   = r_bit + 5'd1;
                            w_shift = {1'b0, r_shift[20:1]};
                            w_tx    = r_shift[1];
                        end
                    end else begin
                        w_baud = r_baud + 8'd1;
                    end
                end
`ifdef FRIDGE_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        w_baud  = 8'd0;
                        w_state = S_STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_baud = r_baud + 8'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_end) begin
                        w_baud  = 8'd0;
                        w_state = S_IDLE;
                        w_tx    = 1'b1;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_baud = r_baud + 8'd1;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_baud  = 8'd0;
                    w_bit   = 5'd0;
                    w_tx    = 1'b1;
                    w_busy  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= 8'd0;
            r_bit   <= 5'd0;
            r_shift <= 21'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef FRIDGE_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef FRIDGE_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fridge_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fridge_status_tx
// Purpose  : Directed self-checking bench for fridge_status_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fridge_status_tx;

    localparam int CPB = 4;
`ifdef FRIDGE_TX_PARITY_EN
    localparam int NB = 24;
`else
    localparam int NB = 23;
`endif

    logic       clk;
    logic       rst_n;
    logic       i;
    logic       req;
    logic [4:0] fgt, frt, fgc, frc;
    logic       ice;
    logic       tx, busy, done;

    int n_checks = 0;
    int n_err    = 0;

    fridge_status_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .i    (i),
        .req  (req),
        .fgt  (fgt),
        .frt  (frt),
        .fgc  (fgc),
        .frc  (frc),
        .ice  (ice),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " tx"},   32'(tx),   32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
    endtask

    // Called just after the edge that accepted req; ends on the done cycle.
    task automatic check_frame(input logic [20:0] snap, input int poke_at,
                               input logic req_during, input string tag);
        logic [23:0] bits;
        bits    = '1;
        bits[0] = 1'b0;
        for (int j = 0; j < 21; j++) bits[j+1] = snap[j];
`ifdef FRIDGE_TX_PARITY_EN
        bits[22] = ^snap;
`endif
        req = req_during;
        for (int k = 0; k < NB * CPB; k++) begin
            if (k == poke_at) begin
                fgt = 5'd31;
                req = 1'b1;
            end else if (k == poke_at + 1) begin
                req = req_during;
            end
            chk($sformatf("%s tx c%0d", tag, k), 32'(tx), 32'(bits[k / CPB]));
            if (k % CPB == 0) begin
                chk($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'd1);
                chk($sformatf("%s done c%0d", tag, k), 32'(done), 32'd0);
            end
            step();
        end
        chk({tag, " done pulse"}, 32'(done), 32'd1);
        chk({tag, " busy end"},   32'(busy), 32'd0);
        chk({tag, " tx end"},     32'(tx),   32'd1);
    endtask

    initial begin
        logic [20:0] exp_a;
        logic [20:0] exp_b;
        exp_a = 21'b1_00111_00011_10010_00100;  // ice=1 frc=7 fgc=3 frt=18 fgt=4
        exp_b = 21'b0_11111_00000_01010_10101;  // ice=0 frc=31 fgc=0 frt=10 fgt=21

        rst_n = 1'b0; i = 1'b1; req = 1'b1;
        fgt = 5'd4; frt = 5'd18; fgc = 5'd3; frc = 5'd7; ice = 1'b1;

        // Reset held with req asserted
        repeat (3) begin
            step();
            chk_idle("reset");
        end
        rst_n = 1'b1;
        req   = 1'b0;
        chk_idle("release");
        step();
        chk_idle("post release");

        // Basic frame
        req = 1'b1;
        step();
        check_frame(exp_a, -1, 1'b0, "basic");
        step();
        chk_idle("basic after");

        // Input change and ignored req during data bit 3
        req = 1'b1;
        step();
        check_frame(exp_a, 17, 1'b0, "snap");
        step();
        chk_idle("snap no 2nd");

        // All ones
        fgt = 5'd31; frt = 5'd31; fgc = 5'd31; frc = 5'd31; ice = 1'b1;
        req = 1'b1;
        step();
        check_frame(21'h1FFFFF, -1, 1'b0, "ones");
        step();
        chk_idle("ones after");

        // Back-to-back: all zeros, then exp_b picked up on the done cycle
        fgt = 5'd0; frt = 5'd0; fgc = 5'd0; frc = 5'd0; ice = 1'b0;
        req = 1'b1;
        step();
        check_frame(21'd0, -1, 1'b1, "b2b1");
        fgt = 5'd21; frt = 5'd10; fgc = 5'd0; frc = 5'd31; ice = 1'b0;
        step();
        check_frame(exp_b, -1, 1'b0, "b2b2");
        step();
        chk_idle("b2b after");

        // Power drop during data bit 10
        fgt = 5'd4; frt = 5'd18; fgc = 5'd3; frc = 5'd7; ice = 1'b1;
        req = 1'b1;
        step();
        req = 1'b0;
        repeat (45) step();
        chk("pwr mid tx",   32'(tx),   32'(exp_a[10]));
        chk("pwr mid busy", 32'(busy), 32'd1);
        i = 1'b0;
        req = 1'b1;
        step();
        chk_idle("pwr drop");
        step();
        chk_idle("pwr off req");
        req = 1'b0;
        i = 1'b1;
        repeat (60) begin
            step();
            chk("pwr no done", 32'(done), 32'd0);
        end
        req = 1'b1;
        step();
        check_frame(exp_a, -1, 1'b0, "fresh");
        step();
        chk_idle("fresh after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
